// File: rtl/discharge_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : discharge_pkg                                                 |
// | Brief   : Shared FSM state encodings and gap classification codes for   |
// |           the discharge-gap breakdown classifier.                       |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package discharge_pkg;

  // Classifier sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_DETECT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Gap classification codes reported on gap_class
  localparam logic [1:0] GC_NONE  = 2'b00;
  localparam logic [1:0] GC_SPARK = 2'b01;
  localparam logic [1:0] GC_SHORT = 2'b10;
  localparam logic [1:0] GC_OPEN  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sample_run_filter.sv
// ---------------------------------------------------------------------------
// | Module  : sample_run_filter                                             |
// | Brief   : Counts consecutive qualifying samples; restarts on any        |
// |           non-qualifying sample, holds between samples, saturates at    |
// |           FILTER_LEN and flags when the run length is reached.          |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module sample_run_filter #(
  parameter int FILTER_LEN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,   // start of a new measurement
  input  logic en,    // a sample is presented this cycle
  input  logic hit,   // the sample satisfies the condition
  output logic full   // run length has reached FILTER_LEN
);

  localparam int CW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next run length: clear, advance with saturation, or restart on a miss
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (!hit) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Run-length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/breakdown_classifier.sv
// ---------------------------------------------------------------------------
// | Module  : breakdown_classifier                                          |
// | Brief   : Classifies a discharge gap as spark, short or open after an   |
// |           arm pulse, ignoring the voltage-rise blanking window and      |
// |           reporting the ignition delay of a spark.                      |
// | Option  : BREAKDOWN_STATS_EN adds saturating per-class event counters.  |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module breakdown_classifier
  import discharge_pkg::*;
#(
  parameter int DW           = 16,
  parameter int TW           = 16,
  parameter int BLANK_CYCLES = 300,
  parameter int FILTER_LEN   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_voltage,
  input  logic signed [DW-1:0] sample_current,
  input  logic                 arm,
  input  logic                 abort,
  input  logic signed [DW-1:0] cfg_vol_hi,
  input  logic signed [DW-1:0] cfg_vol_lo,
  input  logic signed [DW-1:0] cfg_short_vol,
  input  logic signed [DW-1:0] cfg_cur_min,
  input  logic                 cfg_cur_check,
  input  logic        [TW-1:0] cfg_timeout,
  output logic                 is_breakdown,
  output logic        [1:0]    gap_class,
  output logic                 class_valid,
  output logic        [TW-1:0] ignition_delay
`ifdef BREAKDOWN_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic        [31:0]   spark_count,
  output logic        [31:0]   short_count,
  output logic        [31:0]   open_count
`endif
);

  localparam int BW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [TW-1:0]   delay_q, delay_d;
  logic [1:0]      gap_q, gap_d;
  logic            brk_q, brk_d;
  logic            cv_q, cv_d;
  logic [TW-1:0]   ign_q, ign_d;
  logic            filt_clr;

  logic            spark_cond, short_cond;
  logic            spark_full, short_full;
  logic            filt_en;
  logic            blank_last;
  logic [TW-1:0]   delay_inc;

  // Signed window / threshold tests on the current sample
  always_comb begin
    spark_cond = (sample_voltage >= cfg_vol_lo) && (sample_voltage <= cfg_vol_hi)
                 && (!cfg_cur_check || (sample_current >= cfg_cur_min));
    short_cond = (sample_voltage < cfg_short_vol);
  end

  assign filt_en    = (state_q == ST_DETECT) && sample_valid;
  assign blank_last = ((32'(blank_q) + 32'd1) >= 32'(BLANK_CYCLES));
  assign delay_inc  = (&delay_q) ? delay_q : (delay_q + 1'b1);

  sample_run_filter #(.FILTER_LEN(FILTER_LEN)) u_spark_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (filt_clr),
    .en    (filt_en),
    .hit   (spark_cond),
    .full  (spark_full)
  );

  sample_run_filter #(.FILTER_LEN(FILTER_LEN)) u_short_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (filt_clr),
    .en    (filt_en),
    .hit   (short_cond),
    .full  (short_full)
  );

  // Sequencing: next state, delay/blank counters and classification results
  always_comb begin
    state_d  = state_q;
    blank_d  = blank_q;
    delay_d  = delay_q;
    gap_d    = gap_q;
    brk_d    = brk_q;
    cv_d     = 1'b0;
    ign_d    = ign_q;
    filt_clr = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d  = (BLANK_CYCLES == 0) ? ST_DETECT : ST_BLANK;
          blank_d  = '0;
          delay_d  = '0;
          gap_d    = GC_NONE;
          brk_d    = 1'b0;
          filt_clr = 1'b1;
        end
      end
      ST_BLANK: begin
        delay_d = delay_inc;
        if (blank_last) begin
          state_d = ST_DETECT;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_DETECT: begin
        delay_d = delay_inc;
        // Short outranks spark; any filter decision outranks the timeout
        if (short_full) begin
          state_d = ST_DONE;
          gap_d   = GC_SHORT;
          brk_d   = 1'b0;
          cv_d    = 1'b1;
        end else if (spark_full) begin
          state_d = ST_DONE;
          gap_d   = GC_SPARK;
          brk_d   = 1'b1;
          cv_d    = 1'b1;
          ign_d   = delay_q;
        end else if (delay_q >= cfg_timeout) begin
          state_d = ST_DONE;
          gap_d   = GC_OPEN;
          brk_d   = 1'b0;
          cv_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous arm or decision
    if (abort) begin
      state_d = ST_IDLE;
      brk_d   = 1'b0;
      cv_d    = 1'b0;
    end
  end

  // Sequencing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blank_q <= '0;
      delay_q <= '0;
      gap_q   <= GC_NONE;
      brk_q   <= 1'b0;
      cv_q    <= 1'b0;
      ign_q   <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      delay_q <= delay_d;
      gap_q   <= gap_d;
      brk_q   <= brk_d;
      cv_q    <= cv_d;
      ign_q   <= ign_d;
    end
  end

  assign is_breakdown   = brk_q;
  assign gap_class      = gap_q;
  assign class_valid    = cv_q;
  assign ignition_delay = ign_q;

`ifdef BREAKDOWN_STATS_EN
  logic [31:0] spark_cnt_q, spark_cnt_d;
  logic [31:0] short_cnt_q, short_cnt_d;
  logic [31:0] open_cnt_q,  open_cnt_d;

  // Per-class saturating event counters; clear outranks increment
  always_comb begin
    spark_cnt_d = spark_cnt_q;
    short_cnt_d = short_cnt_q;
    open_cnt_d  = open_cnt_q;
    if (stats_clr) begin
      spark_cnt_d = '0;
      short_cnt_d = '0;
      open_cnt_d  = '0;
    end else if (cv_d) begin
      if (gap_d == GC_SPARK && !(&spark_cnt_q)) spark_cnt_d = spark_cnt_q + 1'b1;
      if (gap_d == GC_SHORT && !(&short_cnt_q)) short_cnt_d = short_cnt_q + 1'b1;
      if (gap_d == GC_OPEN  && !(&open_cnt_q))  open_cnt_d  = open_cnt_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spark_cnt_q <= '0;
      short_cnt_q <= '0;
      open_cnt_q  <= '0;
    end else begin
      spark_cnt_q <= spark_cnt_d;
      short_cnt_q <= short_cnt_d;
      open_cnt_q  <= open_cnt_d;
    end
  end

  assign spark_count = spark_cnt_q;
  assign short_count = short_cnt_q;
  assign open_count  = open_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_breakdown_classifier.sv
// ---------------------------------------------------------------------------
// | Module  : tb_breakdown_classifier                                       |
// | Brief   : Directed self-checking bench for breakdown_classifier with    |
// |           default parameters (BLANK_CYCLES=300, FILTER_LEN=10).         |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_breakdown_classifier;

  localparam int DW = 16;
  localparam int TW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_valid;
  logic signed [DW-1:0] sample_voltage;
  logic signed [DW-1:0] sample_current;
  logic                 arm;
  logic                 abort;
  logic signed [DW-1:0] cfg_vol_hi;
  logic signed [DW-1:0] cfg_vol_lo;
  logic signed [DW-1:0] cfg_short_vol;
  logic signed [DW-1:0] cfg_cur_min;
  logic                 cfg_cur_check;
  logic        [TW-1:0] cfg_timeout;
  logic                 is_breakdown;
  logic        [1:0]    gap_class;
  logic                 class_valid;
  logic        [TW-1:0] ignition_delay;
`ifdef BREAKDOWN_STATS_EN
  logic                 stats_clr;
  logic        [31:0]   spark_count;
  logic        [31:0]   short_count;
  logic        [31:0]   open_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cv_seen  = 0;

  always #5 clk = ~clk;

  breakdown_classifier #(
    .DW(DW), .TW(TW), .BLANK_CYCLES(300), .FILTER_LEN(10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid   (sample_valid),
    .sample_voltage (sample_voltage),
    .sample_current (sample_current),
    .arm            (arm),
    .abort          (abort),
    .cfg_vol_hi     (cfg_vol_hi),
    .cfg_vol_lo     (cfg_vol_lo),
    .cfg_short_vol  (cfg_short_vol),
    .cfg_cur_min    (cfg_cur_min),
    .cfg_cur_check  (cfg_cur_check),
    .cfg_timeout    (cfg_timeout),
    .is_breakdown   (is_breakdown),
    .gap_class      (gap_class),
    .class_valid    (class_valid),
    .ignition_delay (ignition_delay)
`ifdef BREAKDOWN_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .spark_count    (spark_count),
    .short_count    (short_count),
    .open_count     (open_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (class_valid) cv_seen++;
  endtask

  // Arm pulse; afterwards cyc counts edges since the arm edge
  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cyc = 0;
    cv_seen = 0;
  endtask

  task automatic wait_cv(input int max_cyc);
    while (!class_valid && cyc < max_cyc) tick();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    sample_valid   = 1'b1;
    sample_voltage = 16'sd25;
    sample_current = 16'sd0;
    arm            = 1'b0;
    abort          = 1'b0;
    cfg_vol_hi     = 16'sd35;
    cfg_vol_lo     = 16'sd8;
    cfg_short_vol  = 16'sd5;
    cfg_cur_min    = 16'sd10;
    cfg_cur_check  = 1'b0;
    cfg_timeout    = 16'd5000;
`ifdef BREAKDOWN_STATS_EN
    stats_clr      = 1'b0;
`endif
    repeat (3) tick();
    check("reset_gap", 32'(gap_class), 32'd0);
    check("reset_brk", 32'(is_breakdown), 32'd0);
    check("reset_cv", 32'(class_valid), 32'd0);
    check("reset_ign", 32'(ignition_delay), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Steady spark: decision at arm + 300 + 10 + 1
    pulse_arm();
    wait_cv(400);
    check("spark_lat", 32'(cyc), 32'd311);
    check("spark_gap", 32'(gap_class), 32'd1);
    check("spark_brk", 32'(is_breakdown), 32'd1);
    check("spark_ign", 32'(ignition_delay), 32'd310);
    tick();
    check("spark_cv_pulse", 32'(class_valid), 32'd0);
    check("spark_hold_gap", 32'(gap_class), 32'd1);

    // Rearm from DONE with a glitch on the 9th detect sample
    pulse_arm();
    check("rearm_gap", 32'(gap_class), 32'd0);
    check("rearm_brk", 32'(is_breakdown), 32'd0);
    run_to(308);
    sample_voltage = 16'sd50;
    tick();
    sample_voltage = 16'sd25;
    wait_cv(400);
    check("glitch_lat", 32'(cyc), 32'd320);
    check("glitch_gap", 32'(gap_class), 32'd1);
    check("glitch_ign", 32'(ignition_delay), 32'd319);

    // Short gap
    sample_voltage = 16'sd2;
    pulse_arm();
    wait_cv(400);
    check("short_lat", 32'(cyc), 32'd311);
    check("short_gap", 32'(gap_class), 32'd2);
    check("short_brk", 32'(is_breakdown), 32'd0);

    // Open gap by timeout at delay count 1000
    sample_voltage = 16'sd80;
    cfg_timeout    = 16'd1000;
    pulse_arm();
    wait_cv(1200);
    check("open_lat", 32'(cyc), 32'd1001);
    check("open_gap", 32'(gap_class), 32'd3);
    check("open_brk", 32'(is_breakdown), 32'd0);

    // Current qualification: too little current never sparks
    sample_voltage = 16'sd25;
    sample_current = 16'sd5;
    cfg_cur_check  = 1'b1;
    cfg_timeout    = 16'd400;
    pulse_arm();
    wait_cv(600);
    check("cur_low_lat", 32'(cyc), 32'd401);
    check("cur_low_gap", 32'(gap_class), 32'd3);
    sample_current = 16'sd12;
    pulse_arm();
    wait_cv(600);
    check("cur_ok_lat", 32'(cyc), 32'd311);
    check("cur_ok_gap", 32'(gap_class), 32'd1);
    check("cur_ok_ign", 32'(ignition_delay), 32'd310);
    cfg_cur_check = 1'b0;
    cfg_timeout   = 16'd5000;

    // Re-arm in BLANK and in DETECT is ignored
    pulse_arm();
    run_to(99);
    arm = 1'b1; tick(); arm = 1'b0;
    run_to(304);
    arm = 1'b1; tick(); arm = 1'b0;
    wait_cv(400);
    check("arm_ign_lat", 32'(cyc), 32'd311);
    check("arm_ign_gap", 32'(gap_class), 32'd1);

    // Abort mid-DETECT at delay 305: no classification follows
    pulse_arm();
    run_to(305);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_brk", 32'(is_breakdown), 32'd0);
    run_to(400);
    check("abort_no_cv", 32'(cv_seen), 32'd0);

    // Abort wins over simultaneous arm in DONE
    pulse_arm();
    wait_cv(400);
    check("pre_abort_brk", 32'(is_breakdown), 32'd1);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    cyc = 0; cv_seen = 0;
    check("abort_arm_brk", 32'(is_breakdown), 32'd0);
    run_to(400);
    check("abort_arm_no_cv", 32'(cv_seen), 32'd0);

    // Reset in DONE clears every output
    pulse_arm();
    wait_cv(400);
    check("pre_rst_gap", 32'(gap_class), 32'd1);
    rst_n = 1'b0;
    #2;
    check("rst_done_gap", 32'(gap_class), 32'd0);
    check("rst_done_brk", 32'(is_breakdown), 32'd0);
    check("rst_done_cv", 32'(class_valid), 32'd0);
    check("rst_done_ign", 32'(ignition_delay), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/breakdown_classifier.md
BREAKDOWN_CLASSIFIER -- requirements
Module: breakdown_classifier

Interface
REQ-001 SHALL have parameter DW, default 16: sample and threshold width, signed.
REQ-002 SHALL have parameter TW, default 16: ignition-delay/timeout counter width.
REQ-003 SHALL have parameter BLANK_CYCLES, default 300: clk cycles ignored after arm (voltage rise slope).
REQ-004 SHALL have parameter FILTER_LEN, default 10: consecutive qualifying samples required to decide.
REQ-005 SHALL have ports: clk input 1 (100 MHz); rst_n input 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: sample_valid in 1; sample_voltage in DW signed (V); sample_current in DW signed (A).
REQ-007 SHALL have ports: arm in 1 (pulse, wait-breakdown entered); abort in 1 (pulse, deionisation entered).
REQ-008 SHALL have ports: cfg_vol_hi, cfg_vol_lo, cfg_short_vol, cfg_cur_min in DW signed; cfg_cur_check in 1; cfg_timeout in TW.
REQ-009 SHALL have ports: is_breakdown out 1; gap_class out 2 (00 none, 01 spark, 10 short, 11 open); class_valid out 1 (one-cycle pulse); ignition_delay out TW.

Function
REQ-010 SHALL implement an FSM with states IDLE, BLANK, DETECT, DONE.
REQ-011 IDLE + arm SHALL enter BLANK, clear the delay counter, clear both filter counters, set gap_class 00.
REQ-012 BLANK SHALL last exactly BLANK_CYCLES clk cycles, then enter DETECT; BLANK_CYCLES=0 SHALL enter DETECT the cycle after arm.
REQ-013 The delay counter SHALL increment every clk in BLANK and DETECT and saturate at all-ones.
REQ-014 Spark condition: cfg_vol_lo <= v <= cfg_vol_hi, ANDed with i >= cfg_cur_min only when cfg_cur_check=1; signed compares.
REQ-015 Short condition: v < cfg_short_vol.
REQ-016 In DETECT, on sample_valid, each filter counter SHALL increment if its condition holds, else clear; counters SHALL hold when sample_valid=0 and saturate at FILTER_LEN.
REQ-017 Spark counter reaching FILTER_LEN SHALL next cycle enter DONE, gap_class=01, is_breakdown=1, class_valid=1, ignition_delay=delay counter.
REQ-018 Short counter reaching FILTER_LEN SHALL enter DONE with gap_class=10, is_breakdown=0, class_valid=1; short SHALL win if both reach on the same cycle.
REQ-019 Delay counter reaching cfg_timeout in DETECT without decision SHALL enter DONE, gap_class=11, class_valid=1; a filter decision the same cycle SHALL win.
REQ-020 DONE SHALL hold gap_class, is_breakdown and ignition_delay; arm in DONE SHALL restart as from IDLE.
REQ-021 abort in any state SHALL next cycle enter IDLE, clear is_breakdown, suppress class_valid; abort SHALL win over simultaneous arm.
REQ-022 arm in BLANK or DETECT SHALL be ignored.

Reset
REQ-023 rst_n low SHALL force IDLE and all outputs, counters and statistics to zero.

Configuration
REQ-024 BREAKDOWN_STATS_EN defined SHALL add outputs spark_count, short_count, open_count (32 bit, saturating, incremented on class_valid per class) and input stats_clr (sync clear, wins over increment).
REQ-025 BREAKDOWN_STATS_EN undefined SHALL remove those ports and counters with no other behavioural change.

Structure
REQ-026 FSM state encodings and gap_class codes SHALL live in shared package discharge_pkg.
REQ-027 The per-condition consecutive-sample filter SHALL be sub-module sample_run_filter, instantiated twice.

Verification
REQ-028 arm, v=25 every cycle from cycle 0, cfg_vol_lo=8, hi=35 -> class_valid at arm+BLANK_CYCLES+FILTER_LEN+1, gap_class=01, ignition_delay=310.
REQ-029 v=25 with one v=50 glitch at the 9th sample -> filter restarts; decision 9 samples later than REQ-028.
REQ-030 v=2, cfg_short_vol=5 -> gap_class=10, is_breakdown=0.
REQ-031 v=80 constant, cfg_timeout=1000 -> gap_class=11 at delay count 1000.
REQ-032 cfg_cur_check=1, cur_min=10, i=5, v=25 -> no spark; i=12 -> spark.
REQ-033 abort at delay 305 mid-DETECT -> IDLE, no class_valid; rst_n low in DONE -> all outputs 0.
